// File: rtl/freq_pkg.sv
// freq_pkg: values shared by the square-wave generator and its divider.
//   FREQ_CLK_HZ : default system clock rate in Hz (dividend of the half-period division)
//   FREQ_WIDTH  : default width of the frequency / half-period datapaths
//   state_e     : control FSM encodings of freq_gen
package freq_pkg;

  localparam int unsigned FREQ_CLK_HZ = 50_000_000;
  localparam int unsigned FREQ_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DIVIDE     = 2'd1,
    ST_WAIT_APPLY = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
//   CLK, RST_N : clock, asynchronous active-low reset
//   start      : begin a division (must not be raised while a division is running)
//   dividend   : WIDTH-bit numerator, sampled with start
//   divisor    : WIDTH+1-bit denominator, sampled with start (0 gives an all-ones quotient)
//   quotient   : result, valid while done is high and held afterwards
//   done       : one-cycle pulse exactly WIDTH+1 cycles after start
module seq_divider
  import freq_pkg::*;
#(
  parameter int unsigned WIDTH = FREQ_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Partial remainder shifted left with the next dividend bit brought in.
  // The remainder is always below the divisor, so WIDTH+2 bits cannot overflow.
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   diff;
  logic             fits;

  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign fits  = (trial >= {1'b0, dvs_q});
  assign diff  = trial[WIDTH:0] - dvs_q;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        // Dividend bits shift out of quo_q's MSB as quotient bits shift in at its LSB.
        rem_d = fits ? diff : trial[WIDTH:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        cnt_d = cnt_q - CW'(1);
      end else begin
        // Extra cycle after the last iteration so done lands at start + WIDTH + 1.
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Datapath registers carry no reset; they are only observed after a start.
  always_ff @(posedge CLK) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/freq_gen.sv
// freq_gen: programmable 50 % duty square-wave generator.
//   CLK, RST_N : system clock, asynchronous active-low reset
//   freq_in    : requested frequency in Hz, sampled when load && ready
//   load       : one-cycle request strobe, dropped while ready is low
//   ready      : a new load will be accepted
//   OUT        : generated square wave (registered)
//   active     : OUT is toggling
//   cur_freq   : frequency currently applied to OUT
// half = floor(CLK_HZ / (2*freq)), clamped to 1. New settings are applied on a
// terminal count of the half-period counter so OUT never shows a short pulse.
module freq_gen
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ = FREQ_CLK_HZ,
  parameter int unsigned WIDTH  = FREQ_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] freq_in,
  input  logic             load,
  output logic             ready,
  output logic             OUT,
  output logic             active,
  output logic [WIDTH-1:0] cur_freq
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic             ready_q;
  logic [WIDTH-1:0] freq_lat_q;
  logic [WIDTH-1:0] pend_half_q;
  logic             pend_stop_q;
  logic [WIDTH-1:0] half_q;
  logic [WIDTH-1:0] cnt_q;
  logic             out_q;
  logic             active_q;
  logic [WIDTH-1:0] cur_freq_q;

  logic             div_start;
  logic [WIDTH-1:0] div_quo;
  logic             div_done;
  logic [WIDTH-1:0] half_sel;
  logic             tc;
  logic             apply;

  // ready_q is high only in IDLE, so it alone qualifies the accept.
  assign div_start = ready_q && load && (freq_in != '0);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (div_start),
    .dividend (WIDTH'(CLK_HZ)),
    .divisor  ({freq_in, 1'b0}),
    .quotient (div_quo),
    .done     (div_done)
  );

  // A zero quotient means freq > CLK_HZ/2; the fastest we can do is toggle every cycle.
  assign half_sel = (div_quo == '0) ? ONE : div_quo;

  assign tc    = active_q && (cnt_q == '0);
  // Running: wait for the terminal count. Stopped: nothing to stay in phase with.
  assign apply = (state_q == ST_WAIT_APPLY) && (!active_q || tc);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      freq_lat_q  <= '0;
      pend_half_q <= '0;
      pend_stop_q <= 1'b0;
      half_q      <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      active_q    <= 1'b0;
      cur_freq_q  <= '0;
    end else begin
      // Control FSM
      case (state_q)
        ST_IDLE: begin
          if (load && ready_q) begin
            freq_lat_q  <= freq_in;
            ready_q     <= 1'b0;
            pend_stop_q <= (freq_in == '0);
            state_q     <= (freq_in == '0) ? ST_WAIT_APPLY : ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            pend_half_q <= half_sel;
            state_q     <= ST_WAIT_APPLY;
          end
        end
        ST_WAIT_APPLY: begin
          if (apply) begin
            cur_freq_q <= freq_lat_q;
            ready_q    <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase

      // Half-period generator
      if (apply) begin
        if (pend_stop_q) begin
          out_q    <= 1'b0;
          active_q <= 1'b0;
          half_q   <= '0;
          cnt_q    <= '0;
        end else if (active_q) begin
          out_q  <= ~out_q;
          half_q <= pend_half_q;
          cnt_q  <= pend_half_q - ONE;
        end else begin
          // Start from stopped: first rising edge lands half cycles from now.
          out_q    <= 1'b0;
          active_q <= 1'b1;
          half_q   <= pend_half_q;
          cnt_q    <= pend_half_q - ONE;
        end
      end else if (tc) begin
        out_q <= ~out_q;
        cnt_q <= half_q - ONE;
      end else if (active_q) begin
        cnt_q <= cnt_q - ONE;
      end
    end
  end

  assign ready    = ready_q;
  assign OUT      = out_q;
  assign active   = active_q;
  assign cur_freq = cur_freq_q;

endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: scoreboard bench for freq_gen with CLK_HZ = 1000 so periods stay short.
// Stimulus pushes {freq, half} when a load is issued; the monitor pops an entry on
// every rising edge of ready (an apply) and checks every OUT edge spacing.
module tb_freq_gen;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] freq_in = '0;
  logic         ready;
  logic         OUT;
  logic         active;
  logic [W-1:0] cur_freq;

  always #5 CLK = ~CLK;

  freq_gen #(.CLK_HZ(1000), .WIDTH(W)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .freq_in  (freq_in),
    .load     (load),
    .ready    (ready),
    .OUT      (OUT),
    .active   (active),
    .cur_freq (cur_freq)
  );

  typedef struct {
    int unsigned freq;
    int unsigned half;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned exp_half = 0;   // half-period expected on OUT, 0 = stopped
  int unsigned last_edge = 0;
  logic        prev_ready = 1'b1;
  logic        prev_out = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: OUT edge spacing and applied settings
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (!RST_N) begin
      prev_ready = ready;
      prev_out   = OUT;
    end else begin
      if (OUT !== prev_out) begin
        if (exp_half == 0) chk("edge_while_stopped", OUT, prev_out);
        else               chk("half_period", cyc - last_edge, exp_half);
        last_edge = cyc;
      end
      if (ready === 1'b1 && prev_ready === 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("apply_without_load", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk("cur_freq", cur_freq, e.freq);
          chk("active", active, e.freq != 0);
          if (exp_half == 0 && e.half != 0) last_edge = cyc;
          exp_half = e.half;
        end
      end
      prev_ready = ready;
      prev_out   = OUT;
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_ready(input int max);
    int n = 0;
    while (ready !== 1'b1 && n < max) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_timeout", ready, 1);
  endtask

  task automatic issue(input int unsigned f, input int unsigned h);
    wait_ready(400);
    @(posedge CLK); #1;
    freq_in = f;
    load    = 1'b1;
    sb_q.push_back('{f, h});
    @(posedge CLK); #1;
    load = 1'b0;
  endtask

  task automatic wait_applied(input int max);
    int n = 0;
    while (sb_q.size() != 0 && n < max) begin
      @(negedge CLK);
      n++;
    end
    chk("apply_timeout", sb_q.size(), 0);
  endtask

  initial begin
    // Reset values
    RST_N = 1'b0;
    run(3);
    chk("rst_ready", ready, 1);
    chk("rst_out", OUT, 0);
    chk("rst_active", active, 0);
    chk("rst_cur_freq", cur_freq, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    run(40);
    chk("idle_out", OUT, 0);
    chk("idle_active", active, 0);

    // Start from stopped, then retune while running
    issue(50, 10);    wait_applied(100); run(70);
    issue(10, 50);    wait_applied(200); run(220);
    // Above CLK_HZ/2 clamps to half = 1; exactly CLK_HZ/2 also gives 1
    issue(1000, 1);   wait_applied(200); run(20);
    issue(500, 1);    wait_applied(100); run(20);
    issue(7, 71);     wait_applied(100); run(300);

    // A load raised during DIVIDE is dropped
    issue(3, 166);
    repeat (5) @(posedge CLK); #1;
    freq_in = 999;
    load    = 1'b1;
    @(posedge CLK); #1;
    load = 1'b0;
    wait_applied(400); run(400);
    chk("dropped_load", cur_freq, 3);

    // Stop while running
    issue(0, 0);      wait_applied(400); run(200);
    chk("stop_out", OUT, 0);
    chk("stop_active", active, 0);
    chk("stop_cur_freq", cur_freq, 0);

    // Stop while already stopped completes in one cycle
    issue(0, 0);
    @(negedge CLK);
    chk("stop_idle_busy", ready, 0);
    @(negedge CLK);
    chk("stop_idle_done", ready, 1);

    // Reset in the middle of a division
    issue(50, 10);
    repeat (10) @(posedge CLK); #1;
    RST_N = 1'b0;
    sb_q.delete();
    exp_half = 0;
    @(negedge CLK);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_out", OUT, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_cur_freq", cur_freq, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    run(60);
    chk("post_rst_cur_freq", cur_freq, 0);
    chk("post_rst_out", OUT, 0);
    issue(1000, 1);   wait_applied(100); run(10);
    chk("post_rst_run", cur_freq, 1000);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
- Programmable square-wave generator: the transmit-side counterpart of freq_counter.
- Takes a 32-bit target frequency in Hz and produces a 50 % duty square wave on OUT, derived from the 50 MHz system clock.
- Used for board self-test: OUT loops back into freq_counter.IN, and cur_freq can drive disp_controller.
- Half-period is computed by an on-chip sequential divider. New settings take effect glitch-free at the next OUT edge.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; dividend for the half-period computation.
- WIDTH, 32, width of the frequency and half-period datapaths.

Ports:
- CLK  input  1  system clock, 50 MHz.
- RST_N  input  1  asynchronous, active-low reset.
- freq_in  input  WIDTH  requested frequency in Hz; sampled when load && ready.
- load  input  1  request strobe, one cycle; ignored when ready=0.
- ready  output  1  high when a new load will be accepted.
- OUT  output  1  generated square wave, registered.
- active  output  1  high while OUT is toggling (applied frequency nonzero).
- cur_freq  output  WIDTH  frequency currently applied to OUT.

Behaviour:
- Reset (async assert, sync release): ready=1, OUT=0, active=0, cur_freq=0, counter=0, FSM=IDLE, pending cleared. Asserting RST_N mid-division or mid-pending aborts the operation with no partial update.
- FSM states: IDLE, DIVIDE, WAIT_APPLY.
  - IDLE: on load && ready, latch freq_in and set ready=0.
    - freq_in=0: go straight to WAIT_APPLY with stop flag set.
    - Otherwise: start divider with dividend=CLK_HZ, divisor=2*freq_in (computed at WIDTH+1 bits, no overflow); go to DIVIDE.
  - DIVIDE: wait for divider done, which is exactly WIDTH+1 cycles after start. Then half = quotient; if quotient==0 (freq_in > CLK_HZ/2), half = 1. Store half in the pending register and go to WAIT_APPLY.
  - WAIT_APPLY, generator running (active=1): apply pending on the cycle the counter reaches 0.
  - WAIT_APPLY, generator stopped (active=0): apply on the next cycle.
  - After applying: update cur_freq, return to IDLE, ready=1.
- Generator:
  - Down-counter loaded with half-1. At 0: toggle OUT and reload, using pending half if an apply occurs that cycle, else the current half.
  - OUT period is exactly 2*half CLK cycles; duty is exactly 50 %.
- Start from stopped: OUT=0, counter=half-1, active=1. The first rising edge of OUT occurs half cycles after the apply.
- Stop (apply with freq 0): at the next terminal count, OUT forced 0 instead of toggling, active=0, cur_freq=0. A stop while already stopped completes in one cycle.
- Truncation: half = floor(CLK_HZ/(2*freq)). cur_freq reports the requested value, not the achieved one.
- A load while ready=0 is dropped; there is no queueing.
- Divider: restoring, 1 quotient bit per cycle. A start while busy is impossible by construction.

Decomposition:
- Shared package freq_pkg:
  - CLK_HZ default (50_000_000)
  - WIDTH
  - FSM state encodings (IDLE/DIVIDE/WAIT_APPLY)
- Sub-module: seq_divider.
  - Ports: CLK, RST_N, start, dividend[WIDTH-1:0], divisor[WIDTH:0], quotient[WIDTH-1:0], done.
  - done is a one-cycle pulse.
  - Divide-by-zero returns an all-ones quotient (never exercised by freq_gen).

Test Plan:
- Reset: hold RST_N=0 -> ready=1, OUT=0, active=0, cur_freq=0. Release; no load -> OUT stays 0 indefinitely.
- Load 50 -> ready low for 33 cycles plus apply. OUT first rises 500_000 CLK cycles after apply; period 1_000_000 cycles (20 ms); cur_freq=50. Loopback into freq_counter reads freq=50.
- Load 1000 while running at 50 -> OUT's current half-period completes unchanged, then 25_000-cycle half-periods with no short pulse. ready returns high at that edge.
- Load 30_000_000 -> half clamped to 1 and OUT toggles every CLK (25 MHz). Load 25_000_000 -> half=1, same output.
- Load 0 while running -> OUT goes low at the next terminal count and stays low; active=0, cur_freq=0. A load asserted during DIVIDE is ignored: cur_freq never takes that value.
- Assert RST_N=0 mid-DIVIDE, then release -> all outputs at reset values and ready=1. A subsequent load of 1000 behaves as in the 1000 Hz-from-stopped case.
